// File: rtl/stream_demux_pkg.sv
//------------------------------------------------------------------------------
// Module   : stream_demux_pkg
// Brief    : Shared sizing helpers and types for the stream_demux block.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package stream_demux_pkg;

    localparam int DEMUX_MAX_OUT   = 64;
    localparam int DEMUX_SEL_MAX_W = 6;

    typedef logic [DEMUX_SEL_MAX_W-1:0] demux_sel_t;

    // A single-channel select still needs a one-bit port.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
//------------------------------------------------------------------------------
// Module   : demux_slot
// Brief    : One-entry output register slice; drain and refill in one cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demux_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              free
);

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign free  = !valid_q || ready;

endmodule

`default_nettype wire

// File: rtl/stream_demux.sv
//------------------------------------------------------------------------------
// Module   : stream_demux
// Brief    : Valid/ready stream demultiplexer to N_OUT independently stalling
//            channels. Define STREAM_DEMUX_BCAST_EN to add the in_bcast port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  N_OUT  = 8,
    localparam int SEL_W  = clog2_min1(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
`ifdef STREAM_DEMUX_BCAST_EN
    input  logic                    in_bcast,
`endif
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic                    err_sel,
    input  logic                    err_clr
);

    localparam int PAD_W = 1 << SEL_W;

    logic [N_OUT-1:0] w_slot_free;
    logic [N_OUT-1:0] w_load;
    logic [PAD_W-1:0] w_free_pad;
    logic [PAD_W-1:0] w_range_pad;
    logic             w_bcast;
    logic             w_in_range;
    logic             w_accept;
    logic             err_sel_q;
    logic             err_sel_d;

`ifdef STREAM_DEMUX_BCAST_EN
    assign w_bcast = in_bcast;
`else
    assign w_bcast = 1'b0;
`endif

    // Unused select codes read as "free" so out-of-range beats are swallowed.
    always_comb begin
        w_free_pad              = '1;
        w_free_pad[N_OUT-1:0]   = w_slot_free;
        w_range_pad             = '0;
        w_range_pad[N_OUT-1:0]  = '1;
        w_in_range              = w_range_pad[in_sel];
        in_ready                = w_bcast ? (&w_slot_free) : w_free_pad[in_sel];
        w_accept                = in_valid && in_ready;

        err_sel_d = err_sel_q;
        if (err_clr) begin
            err_sel_d = 1'b0;
        end
        if (w_accept && !w_bcast && !w_in_range) begin
            err_sel_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sel_q <= 1'b0;
        end else begin
            err_sel_q <= err_sel_d;
        end
    end

    assign err_sel = err_sel_q;

    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_slot
            assign w_load[k] = w_accept && (w_bcast || (in_sel == SEL_W'(k)));

            demux_slot #(
                .DATA_W (DATA_W)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .load      (w_load[k]),
                .load_data (in_data),
                .ready     (out_ready[k]),
                .valid     (out_valid[k]),
                .data      (out_data[k*DATA_W +: DATA_W]),
                .free      (w_slot_free[k])
            );
        end
    endgenerate

endmodule

`default_nettype wire
